// File: rtl/uw_channel_sequencer_if.sv
// uw_channel_sequencer_if
//   Bundles the run-control, channel handshake and status signals of the
//   UW_Channel sequencer.
//   master : the sequencer. It drives ch_init and the status outputs.
//   slave  : the host and channel side. It drives start/abort/config and
//            the channel done/error levels.
//   Signals:
//     start, abort            run control from the host
//     chan_mask, timeout_cycles  run configuration, latched on start
//     ch_init                 one-hot init pulses to the channels
//     ch_done, ch_err         per-channel TXN_DONE and ERROR levels
//     busy, cur_ch            run-in-progress flag and active channel index
//     seq_done, pass          end-of-run pulse and its pass flag
//     err_vec, tmo_vec        per-channel error and timeout results
interface uw_channel_sequencer_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned TMO_W  = 16
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              start;
    logic              abort;
    logic [NUM_CH-1:0] chan_mask;
    logic [TMO_W-1:0]  timeout_cycles;
    logic [NUM_CH-1:0] ch_init;
    logic [NUM_CH-1:0] ch_done;
    logic [NUM_CH-1:0] ch_err;
    logic              busy;
    logic [CW-1:0]     cur_ch;
    logic              seq_done;
    logic              pass;
    logic [NUM_CH-1:0] err_vec;
    logic [NUM_CH-1:0] tmo_vec;

    modport master (
        input  start, abort, chan_mask, timeout_cycles, ch_done, ch_err,
        output ch_init, busy, cur_ch, seq_done, pass, err_vec, tmo_vec
    );

    modport slave (
        output start, abort, chan_mask, timeout_cycles, ch_done, ch_err,
        input  ch_init, busy, cur_ch, seq_done, pass, err_vec, tmo_vec
    );
endinterface

// File: rtl/uw_channel_sequencer.sv
// uw_channel_sequencer
//   Fires each enabled UW_Channel engine's INIT_AXI_TXN in ascending channel
//   order. For each channel it waits for a rising edge on TXN_DONE and
//   records ERROR. If the optional timeout expires first, the channel is
//   abandoned and flagged. Each completed run produces one seq_done/pass
//   summary.
//   Ports:
//     ACLK    clock; all logic runs on its rising edge
//     ARESET  synchronous, active-high reset
//     bus     uw_channel_sequencer_if.master. Carries the control inputs,
//             the channel handshake and the registered status outputs.
module uw_channel_sequencer #(
    parameter int unsigned NUM_CH     = 8,
    parameter int unsigned GAP_CYCLES = 20,
    parameter int unsigned INIT_PULSE = 2,
    parameter int unsigned TMO_W      = 16
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    uw_channel_sequencer_if.master bus
);
    localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] GAP_LAST   = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
    localparam logic [31:0] PULSE_LAST = (INIT_PULSE == 0) ? 32'd0 : 32'(INIT_PULSE - 1);

    typedef enum logic [2:0] {S_IDLE, S_GAP, S_PULSE, S_WAIT, S_FIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cur_q, cur_d;
    logic [NUM_CH-1:0] rem_q, rem_d;
    logic [TMO_W-1:0]  tmo_lim_q, tmo_lim_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [31:0]       ph_cnt_q, ph_cnt_d;
    logic              done_q, done_d;
    logic [NUM_CH-1:0] err_q, err_d;
    logic [NUM_CH-1:0] tmo_q, tmo_d;
    logic [NUM_CH-1:0] ch_init_q, ch_init_d;
    logic              busy_q, busy_d;
    logic              seq_done_q, seq_done_d;
    logic              pass_q, pass_d;
    logic              done_edge;
    logic              advance;

    function automatic logic [CW-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [CW-1:0] idx;
        idx = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (v[i-1]) idx = CW'(i - 1);
        end
        return idx;
    endfunction

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        tmo_lim_d = tmo_lim_q;
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        ph_cnt_d  = ph_cnt_q + 32'd1;
        err_d     = err_q;
        tmo_d     = tmo_q;
        advance   = 1'b0;
        done_d    = bus.ch_done[cur_q];
        done_edge = bus.ch_done[cur_q] & ~done_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rem_d     = bus.chan_mask;
                    tmo_lim_d = bus.timeout_cycles;
                    err_d     = '0;
                    tmo_d     = '0;
                    advance   = 1'b1;
                end
            end
            S_GAP: begin
                if (ph_cnt_q == GAP_LAST) begin
                    state_d  = S_PULSE;
                    ph_cnt_d = '0;
                end
            end
            S_PULSE: begin
                if (ph_cnt_q == PULSE_LAST) begin
                    state_d   = S_WAIT;
                    tmo_cnt_d = '0;
                end
            end
            S_WAIT: begin
                // A done edge in the same cycle as the timeout takes priority.
                if (done_edge) begin
                    err_d[cur_q] = bus.ch_err[cur_q];
                    advance      = 1'b1;
                end else if ((tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q - TMO_W'(1))) begin
                    tmo_d[cur_q] = 1'b1;
                    advance      = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Shared by start acceptance and channel completion: pick the next
        // enabled channel from rem (already the latched mask on start).
        if (advance) begin
            ph_cnt_d = '0;
            if (rem_d != '0) begin
                cur_d        = lowest_set(rem_d);
                rem_d[cur_d] = 1'b0;
                state_d      = (GAP_CYCLES == 0) ? S_PULSE : S_GAP;
            end else begin
                state_d = S_FIN;
            end
        end

        if (bus.abort && (state_q != S_IDLE)) state_d = S_IDLE;

        // Outputs are decoded from the next state so that they register in
        // step with the state they describe.
        busy_d     = (state_d == S_GAP) || (state_d == S_PULSE) || (state_d == S_WAIT);
        ch_init_d  = (state_d == S_PULSE) ? (NUM_CH'(1) << cur_d) : '0;
        seq_done_d = (state_d == S_FIN);
        pass_d     = (state_d == S_FIN) && (err_d == '0) && (tmo_d == '0);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            rem_q      <= '0;
            tmo_lim_q  <= '0;
            tmo_cnt_q  <= '0;
            ph_cnt_q   <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
            tmo_q      <= '0;
            ch_init_q  <= '0;
            busy_q     <= 1'b0;
            seq_done_q <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            rem_q      <= rem_d;
            tmo_lim_q  <= tmo_lim_d;
            tmo_cnt_q  <= tmo_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            ch_init_q  <= ch_init_d;
            busy_q     <= busy_d;
            seq_done_q <= seq_done_d;
            pass_q     <= pass_d;
        end
    end

    assign bus.ch_init  = ch_init_q;
    assign bus.busy     = busy_q;
    assign bus.cur_ch   = cur_q;
    assign bus.seq_done = seq_done_q;
    assign bus.pass     = pass_q;
    assign bus.err_vec  = err_q;
    assign bus.tmo_vec  = tmo_q;
endmodule
